ecc_fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares one ECC-path FIFO among `NR` independent producers. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time, forwards its accepted words to the FIFO write port (`ffbwreq`/`ffbdi`), and never writes while the FIFO reports full. It sits between the Hamming encoder lanes and the shared FIFO instance.

---
 rtl/ecc_fifo_arb_pkg.sv | 15 +
 rtl/ecc_rr_pick.sv | 35 +++
 rtl/ecc_fifo_wr_arb.sv | 144 ++++++++++++++
 tb/tb_ecc_fifo_wr_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_fifo_arb_pkg.sv
// ecc_fifo_arb_pkg
//   Shared types and default sizing for the ECC FIFO write arbiter slice.
//   arb_state_t : arbiter FSM state (ARB = searching, XFER = grant active)
//   NR_DEFAULT  : default number of requesters
//   FW_DEFAULT  : default data / FIFO width
//   BL_DEFAULT  : default maximum beats per grant in burst builds
package ecc_fifo_arb_pkg;

    typedef enum logic [0:0] {ARB, XFER} arb_state_t;

    localparam int unsigned NR_DEFAULT = 4;
    localparam int unsigned FW_DEFAULT = 8;
    localparam int unsigned BL_DEFAULT = 4;

endpackage

// File: rtl/ecc_rr_pick.sv
// ecc_rr_pick
//   Combinational rotate-priority search: returns the first set bit of
//   req_valid found by scanning upward from rr_ptr, wrapping NR-1 -> 0.
//   Ports:
//     req_valid [NR]   in  request vector
//     rr_ptr    [NRW]  in  index with highest priority
//     any              out at least one request present
//     idx       [NRW]  out selected index (0 when any = 0)
module ecc_rr_pick #(
    parameter int unsigned NR  = 4,
    parameter int unsigned NRW = $clog2(NR)
) (
    input  logic [NR-1:0]  req_valid,
    input  logic [NRW-1:0] rr_ptr,
    output logic           any,
    output logic [NRW-1:0] idx
);

    logic [NRW-1:0] w_cand;

    // Scan from the farthest offset down to offset 0 so the nearest valid
    // index (counting upward from rr_ptr) is the last assignment and wins.
    always_comb begin
        any    = |req_valid;
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = NR; k > 0; k--) begin
            w_cand = NRW'((32'(rr_ptr) + k - 1) % NR);
            if (req_valid[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/ecc_fifo_wr_arb.sv
// ecc_fifo_wr_arb
//   Round-robin write arbiter sharing one ECC-path FIFO among NR producers.
//   One producer is granted at a time; its accepted words go straight to
//   the FIFO write port, and nothing is written while the FIFO is full.
//   Optional feature macro: ECC_FIFO_ARB_BURST_EN
//     defined   : a grant lasts until req_last or BL beats
//     undefined : a grant lasts exactly one beat (req_last, BL unused)
//   Ports:
//     clk                 in  clock, posedge
//     reset_n             in  asynchronous active-low reset
//     req_valid [NR]      in  per-requester word valid
//     req_data  [NR*FW]   in  requester i data at [i*FW +: FW]
//     req_last  [NR]      in  final word of a burst (burst builds only)
//     req_ready [NR]      out per-requester accept
//     ffbwreq             out FIFO write request
//     ffbdi     [FW]      out FIFO write data
//     ffbfull             in  FIFO full
//     grant_vld           out grant active
//     grant_id  [NRW]     out granted requester index
module ecc_fifo_wr_arb
    import ecc_fifo_arb_pkg::*;
#(
    parameter int unsigned NR  = NR_DEFAULT,
    parameter int unsigned FW  = FW_DEFAULT,
    parameter int unsigned BL  = BL_DEFAULT,
    parameter int unsigned NRW = $clog2(NR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NR-1:0]     req_valid,
    input  logic [NR*FW-1:0]  req_data,
    input  logic [NR-1:0]     req_last,
    output logic [NR-1:0]     req_ready,
    output logic              ffbwreq,
    output logic [FW-1:0]     ffbdi,
    input  logic              ffbfull,
    output logic              grant_vld,
    output logic [NRW-1:0]    grant_id
);

    arb_state_t     r_state, w_state_nxt;
    logic [NRW-1:0] r_owner, w_owner_nxt;
    logic [NRW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [NRW-1:0] w_owner_inc;
    logic           w_any;
    logic [NRW-1:0] w_pick;
    logic           w_xfer;
    logic           w_own_valid;
    logic           w_beat;
    logic           w_done;
    logic [FW-1:0]  w_slice [NR];

    ecc_rr_pick #(
        .NR  (NR),
        .NRW (NRW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .any       (w_any),
        .idx       (w_pick)
    );

    for (genvar gi = 0; gi < NR; gi++) begin : g_slice
        assign w_slice[gi] = req_data[gi*FW +: FW];
    end

    assign w_xfer      = (r_state == XFER);
    assign w_own_valid = req_valid[r_owner];
    assign w_beat      = w_xfer & w_own_valid & ~ffbfull;
    assign w_owner_inc = (r_owner == NRW'(NR - 1)) ? '0 : r_owner + 1'b1;

`ifdef ECC_FIFO_ARB_BURST_EN
    localparam int unsigned BCW = $clog2(BL + 1);

    logic [BCW-1:0] r_beat_cnt;

    assign w_done = w_beat & (req_last[r_owner] | ((32'(r_beat_cnt) + 32'd1) == BL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (!w_xfer && w_any) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned bl_unused = BL;

    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_done        = w_beat;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ARB;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // A full FIFO freezes the grant outright, even if the owner drops valid
    // in that cycle; the valid-drop exit is only taken when not full.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        unique case (r_state)
            ARB: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if ((!ffbfull && !w_own_valid) || w_done) begin
                    w_state_nxt  = ARB;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer && !ffbfull) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    assign ffbwreq   = w_beat;
    assign ffbdi     = w_slice[r_owner];
    assign grant_vld = w_xfer;
    assign grant_id  = r_owner;

endmodule

// File: tb/tb_ecc_fifo_wr_arb.sv
module tb_ecc_fifo_wr_arb;

    localparam int unsigned NR = 4;
    localparam int unsigned FW = 8;
    localparam int unsigned BL = 4;
`ifdef ECC_FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR*FW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             ffbwreq;
    logic [FW-1:0]    ffbdi;
    logic             ffbfull;
    logic             grant_vld;
    logic [1:0]       grant_id;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ecc_fifo_wr_arb #(
        .NR (NR),
        .FW (FW),
        .BL (BL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .ffbwreq   (ffbwreq),
        .ffbdi     (ffbdi),
        .ffbfull   (ffbfull),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural reference: a grant record (busy/owner), the round-robin
    // start point and a beat tally, advanced once per cycle from the rules.
    initial begin : model
        bit            m_busy;
        int            m_own;
        int            m_ptr;
        int            m_cnt;
        logic [NR-1:0] e_ready;
        bit            e_beat;
        bit            done;
        m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
                chk("rst_gvld", grant_vld, 0);
                chk("rst_wreq", ffbwreq, 0);
                chk("rst_ready", req_ready, 0);
            end else begin
                e_ready = '0;
                e_beat  = 0;
                if (m_busy) begin
                    if (!ffbfull) e_ready[m_own] = 1'b1;
                    e_beat = req_valid[m_own] && !ffbfull;
                end
                chk("ready", req_ready, e_ready);
                chk("wreq", ffbwreq, e_beat);
                chk("gvld", grant_vld, m_busy);
                chk("gid", grant_id, m_own);
                if (m_busy) chk("data", ffbdi, req_data[m_own*FW +: FW]);
                if (!m_busy) begin
                    for (int k = NR - 1; k >= 0; k--) begin
                        if (req_valid[(m_ptr + k) % NR]) begin
                            m_own  = (m_ptr + k) % NR;
                            m_busy = 1;
                            m_cnt  = 0;
                        end
                    end
                end else if (!ffbfull) begin
                    if (!req_valid[m_own]) begin
                        m_busy = 0;
                        m_ptr  = (m_own + 1) % NR;
                    end else begin
                        m_cnt++;
                        done = BURST ? (req_last[m_own] || m_cnt == BL) : 1'b1;
                        if (done) begin
                            m_busy = 0;
                            m_ptr  = (m_own + 1) % NR;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset(input logic [NR-1:0] v, input logic f);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_gvld", grant_vld, 0);
        chk("async_rst_gid", grant_id, 0);
        req_valid = v;
        req_last  = '0;
        ffbfull   = f;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin : stim
        int q[$];
        bit prev;
        int beats;
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        ffbfull   = 1'b0;

        // Fairness: all valid, FIFO never full.
        do_reset('1, 1'b0);
        prev = 0;
        repeat (40) begin
            @(negedge clk);
            if (grant_vld && !prev) q.push_back(int'(grant_id));
            prev = grant_vld;
            @(posedge clk);
            #1 req_data = $urandom;
        end
        chk("fair_count", q.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) chk("fair_seq", q[i], i % NR);
        end

        // Full stall on requester 2.
        do_reset(4'b0100, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", req_ready, 0);
            chk("stall_wreq", ffbwreq, 0);
            chk("stall_gid", grant_id, 2);
            @(posedge clk);
        end
        #1 ffbfull = 1'b0;
        @(negedge clk);
        chk("unstall_wreq", ffbwreq, 1);
        chk("unstall_ready", req_ready, 4'b0100);

        // Owner drops valid before its first beat.
        do_reset(4'b0001, 1'b0);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("drop_gvld", grant_vld, 1);
        chk("drop_wreq", ffbwreq, 0);
        @(negedge clk);
        chk("drop_exit", grant_vld, 0);

        // Reset in the middle of a beat.
        do_reset('1, 1'b0);
        @(posedge clk);
        #2 chk("mid_beat", ffbwreq, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_wreq", ffbwreq, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_gvld", grant_vld, 0);
        req_valid = 4'b1010;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_gid", grant_id, 1);
        chk("post_rst_gvld", grant_vld, 1);

`ifdef ECC_FIFO_ARB_BURST_EN
        // Burst limit: requester 1 streams, requester 3 waits.
        do_reset(4'b1010, 1'b0);
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_vld && grant_id == 2'd3) break;
            if (ffbwreq && grant_id == 2'd1) beats++;
        end
        chk("burst_beats", beats, BL);
        chk("burst_next", grant_id, 3);

        // Early last on beat 2 of requester 0.
        do_reset(4'b0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 req_last = 4'b0001;
        @(posedge clk);
        #1 req_valid = '1;
        @(negedge clk);
        chk("last_exit", grant_vld, 0);
        @(negedge clk);
        chk("last_rrptr", grant_id, 1);
`endif

        // Randomized traffic against the model.
        do_reset('0, 1'b0);
        repeat (3000) begin
            @(posedge clk);
            #1;
            req_valid = NR'($urandom | $urandom);
            req_last  = NR'($urandom & $urandom);
            ffbfull   = ($urandom_range(0, 4) == 0);
            req_data  = $urandom;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
